// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator behind a valid/ready handshake.
// Holds two entries (output register plus skid) and a saturating delivered-immediate counter.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_src,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_fmt_err,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] imm_cnt
);

  typedef enum logic [2:0] {
    FMT_I     = 3'b000,
    FMT_S     = 3'b001,
    FMT_B     = 3'b010,
    FMT_U     = 3'b011,
    FMT_J     = 3'b100,
    FMT_SHAMT = 3'b101
  } fmt_e;

  logic [XLEN-1:0] ext_imm;
  logic            ext_err;

  logic            skid_empty;
  logic [XLEN-1:0] skid_imm;
  logic            skid_err;

  logic accept;
  logic drain;

  // Size casts of $signed operands sign-extend to XLEN.
  always_comb begin
    ext_imm = '0;
    ext_err = 1'b0;
    case (in_imm_src)
      FMT_I:  ext_imm = XLEN'($signed(in_instr[31:20]));
      FMT_S:  ext_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      FMT_B:  ext_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                       in_instr[11:8], 1'b0}));
      FMT_U:  ext_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
      FMT_J:  ext_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                       in_instr[30:21], 1'b0}));
      FMT_SHAMT: begin
        if (XLEN == 64) ext_imm = XLEN'(in_instr[25:20]);
        else            ext_imm = XLEN'(in_instr[24:20]);
      end
      default: ext_err = 1'b1;
    endcase
  end

  assign in_ready = skid_empty;
  assign accept   = in_valid & skid_empty;
  assign drain    = out_valid & out_ready;

  // The output register refills whenever it is empty or draining, preferring the older skid entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_imm     <= '0;
      out_fmt_err <= 1'b0;
      skid_empty  <= 1'b1;
      skid_imm    <= '0;
      skid_err    <= 1'b0;
    end else if (!out_valid || drain) begin
      if (!skid_empty) begin
        out_valid   <= 1'b1;
        out_imm     <= skid_imm;
        out_fmt_err <= skid_err;
        skid_empty  <= 1'b1;
      end else if (accept) begin
        out_valid   <= 1'b1;
        out_imm     <= ext_imm;
        out_fmt_err <= ext_err;
      end else begin
        out_valid   <= 1'b0;
      end
    end else if (accept) begin
      skid_empty <= 1'b0;
      skid_imm   <= ext_imm;
      skid_err   <= ext_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_cnt <= '0;
    end else if (clr_cnt) begin
      imm_cnt <= '0;
    end else if (drain && (imm_cnt != {CNT_W{1'b1}})) begin
      imm_cnt <= imm_cnt + CNT_W'(1);
    end
  end

endmodule
